weight_stream_buf: RTL and testbench

- Parametrised weight streamer between external weight BRAM and the systolic array.
- Fetches a programmable run of weight lines (N_MACS lanes x DATA_W) from a configurable base address.
- Tolerates configurable BRAM read latency and buffers lines in a credit-managed prefetch FIFO.
- Presents lines to the array under a valid/ready handshake, in broadside mode or diagonal-skew mode (lane i delayed i beats).

---
 rtl/weight_stream_buf.sv | 171 +++++++++++++++++
 tb/tb_weight_stream_buf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_buf.sv
// Weight streamer: fetches a run of weight lines from BRAM through a
// credit-managed prefetch FIFO and presents them to the systolic array,
// either broadside or with lane i skewed by i beats.
module weight_stream_buf #(
  parameter int N_MACS      = 4,
  parameter int DATA_W      = 16,
  parameter int MEM_DEPTH   = 256,
  parameter int RD_LAT      = 1,
  parameter int ADDR_W      = $clog2(MEM_DEPTH),
  parameter int BRAM_ADDR_W = ADDR_W + $clog2(N_MACS*DATA_W/8),
  parameter int FIFO_D      = RD_LAT + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          num_lines,
  input  logic                     skew_mode,
  output logic                     busy,
  output logic                     done,
  output logic                     bram_en,
  output logic [BRAM_ADDR_W-1:0]   bram_addr,
  input  logic [N_MACS*DATA_W-1:0] bram_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_MACS*DATA_W-1:0] w_out,
  output logic [ADDR_W+1:0]        beat_idx
);

  localparam int LINE_W = N_MACS * DATA_W;
  localparam int BYTE_W = BRAM_ADDR_W - ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int CNT_W  = $clog2(FIFO_D + 1);
  localparam int BEAT_W = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     issued_q, num_q;
  logic                skew_q, done_q;
  logic [BEAT_W-1:0]   total_q, beat_q;
  logic [RD_LAT-1:0]   vld_pipe_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, inflight;
  logic [CNT_W:0]      used;
  logic [LINE_W-1:0]   fifo_mem [FIFO_D];
  logic [LINE_W-1:0]   line_in;
  logic [DATA_W-1:0]   dly_tap [1:N_MACS-1];
  logic [ADDR_W-1:0]   line_addr;
  logic start_acc, start_go, need_line, fifo_empty, accept, pop;
  logic last_beat, credit_ok, fetch_issue, wr, done_d;

  // Handshake, credit accounting and read-issue decisions
  always_comb begin
    start_acc  = (state_q == IDLE) && start;
    // The first read goes out in the start cycle itself; held reset blocks it.
    start_go   = start_acc && rst_n && (num_lines != '0);
    need_line  = beat_q < {1'b0, num_q};
    fifo_empty = (count_q == '0);
    out_valid  = (state_q != IDLE) && (beat_q < total_q) && (!need_line || !fifo_empty);
    accept     = out_valid && out_ready;
    pop        = accept && need_line;
    last_beat  = (beat_q == total_q - BEAT_W'(1));
    wr         = vld_pipe_q[RD_LAT-1];
    inflight   = '0;
    for (int k = 0; k < RD_LAT; k++) inflight = inflight + CNT_W'(vld_pipe_q[k]);
    // A pop this cycle frees a slot, which keeps the stream bubble-free.
    used        = {1'b0, count_q} + {1'b0, inflight} - {{CNT_W{1'b0}}, pop};
    credit_ok   = used < (CNT_W+1)'(FIFO_D);
    fetch_issue = (state_q == FETCH) && (issued_q < num_q) && credit_ok;
    bram_en     = start_go || fetch_issue;
    line_addr   = start_go ? base_addr : (fetch_issue ? addr_q : '0);
    bram_addr   = {line_addr, {BYTE_W{1'b0}}};
    done_d      = ((state_q == DRAIN) && accept && last_beat) ||
                  (start_acc && (num_lines == '0));
    line_in     = (need_line && !fifo_empty) ? fifo_mem[rd_ptr_q] : '0;
  end

  // Next-state logic for the run sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = FETCH;
      FETCH:   if ((issued_q + {{ADDR_W{1'b0}}, fetch_issue}) >= num_q) state_d = DRAIN;
      DRAIN:   if (accept && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, run parameters, read counters and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      addr_q   <= '0;
      issued_q <= '0;
      num_q    <= '0;
      skew_q   <= 1'b0;
      total_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        addr_q   <= base_addr + ADDR_W'(1);
        issued_q <= {{ADDR_W{1'b0}}, start_go};
        num_q    <= num_lines;
        skew_q   <= skew_mode;
        total_q  <= {1'b0, num_lines} + (skew_mode ? BEAT_W'(N_MACS - 1) : '0);
        beat_q   <= '0;
      end else begin
        if (fetch_issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + (ADDR_W+1)'(1);
        end
        if (accept) beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  // Return-valid pipe and FIFO pointers; reset drops any in-flight returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      vld_pipe_q[0] <= bram_en;
      for (int k = 1; k < RD_LAT; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
      if (wr) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(wr) - CNT_W'(pop);
    end
  end

  // FIFO storage captures each tagged BRAM return
  always_ff @(posedge clk) begin
    if (wr) fifo_mem[wr_ptr_q] <= bram_dout;
  end

  for (genvar i = 1; i < N_MACS; i++) begin : g_lane
    logic [DATA_W-1:0] dly_q [i];
    // Lane i delay line, i beats deep, advanced only on accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < i; j++) dly_q[j] <= '0;
      end else if (start_acc) begin
        for (int j = 0; j < i; j++) dly_q[j] <= '0;
      end else if (accept) begin
        dly_q[0] <= line_in[i*DATA_W +: DATA_W];
        for (int j = 1; j < i; j++) dly_q[j] <= dly_q[j-1];
      end
    end
    assign dly_tap[i] = dly_q[i-1];
  end

  // Output lanes: lane 0 is never delayed; skew mode taps the delay lines
  always_comb begin
    w_out = line_in;
    if (skew_q) begin
      for (int i = 1; i < N_MACS; i++) w_out[i*DATA_W +: DATA_W] = dly_tap[i];
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign beat_idx = beat_q;

endmodule

// File: tb/tb_weight_stream_buf.sv
// Directed bench for weight_stream_buf: one instance with RD_LAT=1 and one
// with RD_LAT=3, each fed by a behavioural BRAM of matching latency.
module tb_weight_stream_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start1, skew1, rdy1, busy1, done1, en1, v1;
  logic [7:0]  base1;
  logic [8:0]  num1;
  logic [10:0] ba1;
  logic [63:0] dout1, w1;
  logic [9:0]  idx1;

  logic        start3, skew3, rdy3, busy3, done3, en3, v3;
  logic [7:0]  base3;
  logic [8:0]  num3;
  logic [10:0] ba3;
  logic [63:0] dout3, w3;
  logic [9:0]  idx3;

  logic [63:0] mem [256];
  logic [63:0] p3 [3];
  logic [63:0] got [16];
  int addr_log[$];
  int tests = 0;
  int fails = 0;
  int en_cnt1 = 0;

  weight_stream_buf #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1), .num_lines(num1),
    .skew_mode(skew1), .busy(busy1), .done(done1), .bram_en(en1), .bram_addr(ba1),
    .bram_dout(dout1), .out_valid(v1), .out_ready(rdy1), .w_out(w1), .beat_idx(idx1));

  weight_stream_buf #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .base_addr(base3), .num_lines(num3),
    .skew_mode(skew3), .busy(busy3), .done(done3), .bram_en(en3), .bram_addr(ba3),
    .bram_dout(dout3), .out_valid(v3), .out_ready(rdy3), .w_out(w3), .beat_idx(idx3));

  always @(posedge clk) if (en1) dout1 <= mem[ba1[10:3]];
  always @(posedge clk) begin
    if (en3) p3[0] <= mem[ba3[10:3]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout3 = p3[2];
  always @(negedge clk) if (en1) en_cnt1++;

  function automatic logic [63:0] line_of(input int k);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(32'hA000 + k*4 + j);
    return v;
  endfunction

  // Reference beat: lane i carries line (t-i) in skew mode, line t otherwise
  function automatic logic [63:0] exp_beat(input int b, input int n, input bit sk, input int t);
    logic [63:0] r, ln;
    int l;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      l = sk ? t - i : t;
      if (l >= 0 && l < n) begin
        ln = line_of((b + l) % 256);
        r[i*16 +: 16] = ln[i*16 +: 16];
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drv(input int d, input logic s, input logic [7:0] b, input logic [8:0] n,
                     input logic sk, input logic r);
    if (d == 0) begin start1 = s; base1 = b; num1 = n; skew1 = sk; rdy1 = r; end
    else        begin start3 = s; base3 = b; num3 = n; skew3 = sk; rdy3 = r; end
  endtask

  task automatic smp(input int d, output logic v, output logic r, output logic [63:0] w,
                     output logic [9:0] idx, output logic e, output logic [10:0] ba,
                     output logic dn, output logic bz);
    if (d == 0) begin v = v1; r = rdy1; w = w1; idx = idx1; e = en1; ba = ba1; dn = done1; bz = busy1; end
    else        begin v = v3; r = rdy3; w = w3; idx = idx3; e = en3; ba = ba3; dn = done3; bz = busy3; end
  endtask

  // One complete run on instance d; optionally random ready and a start pulse while busy
  task automatic run(input int d, input int b, input int n, input bit sk,
                     input bit rand_rdy, input bit glitch);
    int t, first_v, last_acc, done_cyc, total;
    bit prev_hold;
    logic [63:0] prev_w, w;
    logic [9:0] prev_idx, idx;
    logic [10:0] ba;
    logic v, r, e, dn, bz, s;
    total = sk ? n + 3 : n;
    t = 0; first_v = -1; last_acc = -1; done_cyc = -1; prev_hold = 0;
    prev_w = '0; prev_idx = '0;
    addr_log.delete();
    for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      s = (cyc == 0) || (glitch && (cyc == 1 || cyc == 2));
      drv(d, s, (cyc == 0) ? 8'(b) : 8'd77, (cyc == 0) ? 9'(n) : 9'd5,
          (cyc == 0) ? sk : ~sk, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      smp(d, v, r, w, idx, e, ba, dn, bz);
      if (e) addr_log.push_back(int'(ba[10:3]));
      if (cyc == 1) check("busy_rise", 64'(bz), 64'd1);
      if (prev_hold) begin
        check("hold_w", w, prev_w);
        check("hold_idx", 64'(idx), 64'(prev_idx));
      end
      if (v && first_v < 0) first_v = cyc;
      if (v && r) begin
        check("beat_w", w, exp_beat(b, n, sk, t));
        check("beat_idx", 64'(idx), 64'(t));
        if (t < 16) got[t] = w;
        t++;
        last_acc = cyc;
      end
      prev_hold = v && !r; prev_w = w; prev_idx = idx;
      if (dn) begin
        done_cyc = cyc;
        check("busy_fall", 64'(bz), 64'd0);
      end
    end
    check("beats", 64'(t), 64'(total));
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("done_lat", 64'(done_cyc), 64'(last_acc + 1));
    if (!rand_rdy) begin
      check("first_valid", 64'(first_v), (d == 0) ? 64'd2 : 64'd4);
      check("no_bubble", 64'(last_acc - first_v + 1), 64'(total));
    end
    @(posedge clk); #1;
    drv(d, 1'b0, 8'd0, 9'd0, 1'b0, 1'b1);
    #1;
    smp(d, v, r, w, idx, e, ba, dn, bz);
    check("done_pulse", 64'(dn), 64'd0);
  endtask

  int wa[4] = '{254, 255, 0, 1};
  int cnt0;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = line_of(k);
    rst_n = 1'b0;
    drv(0, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0);
    drv(1, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_en", 64'(en1), 64'd0);
    check("rst_valid", 64'(v1), 64'd0);
    check("rst_w", w1, 64'd0);
    check("rst_idx", 64'(idx1), 64'd0);
    check("rst_addr", 64'(ba1), 64'd0);
    rst_n = 1'b1;

    // Broadside, RD_LAT=1, lines 0..3
    run(0, 0, 4, 1'b0, 1'b0, 1'b0);
    check("bs_beat0", got[0], {16'hA003, 16'hA002, 16'hA001, 16'hA000});
    check("bs_beat3", got[3], {16'hA00F, 16'hA00E, 16'hA00D, 16'hA00C});

    // Diagonal skew on the same data
    run(0, 0, 4, 1'b1, 1'b0, 1'b0);
    check("sk_beat0", got[0], {16'h0000, 16'h0000, 16'h0000, 16'hA000});
    check("sk_beat3", got[3], {16'hA003, 16'hA006, 16'hA009, 16'hA00C});
    check("sk_beat6", got[6], {16'hA00F, 16'h0000, 16'h0000, 16'h0000});

    // Address wrap with RD_LAT=3
    run(1, 254, 4, 1'b0, 1'b0, 1'b0);
    check("wrap_reads", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size()) check("wrap_addr", 64'(addr_log[i]), 64'(wa[i]));
    run(1, 254, 4, 1'b1, 1'b0, 1'b0);

    // Random backpressure in skew mode, with start pulsed while busy
    run(0, 10, 6, 1'b1, 1'b1, 1'b1);
    run(0, 200, 5, 1'b0, 1'b1, 1'b0);

    // Zero-length run
    cnt0 = en_cnt1;
    @(posedge clk); #1;
    drv(0, 1'b1, 8'd5, 9'd0, 1'b0, 1'b1);
    #1;
    check("zl_no_en", 64'(en1), 64'd0);
    @(posedge clk); #1;
    drv(0, 1'b0, 8'd0, 9'd0, 1'b0, 1'b1);
    #1;
    check("zl_done", 64'(done1), 64'd1);
    check("zl_busy", 64'(busy1), 64'd0);
    @(posedge clk); #2;
    check("zl_done_once", 64'(done1), 64'd0);
    check("zl_busy2", 64'(busy1), 64'd0);
    check("zl_en_cnt", 64'(en_cnt1), 64'(cnt0));

    // Reset in DRAIN with a stalled, full FIFO
    @(posedge clk); #1;
    drv(0, 1'b1, 8'd0, 9'd2, 1'b0, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      drv(0, 1'b0, 8'd0, 9'd0, 1'b0, 1'b0);
    end
    #1;
    check("mr_busy", 64'(busy1), 64'd1);
    check("mr_valid", 64'(v1), 64'd1);
    check("mr_w", w1, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
    rst_n = 1'b0;
    #1;
    check("mr_rst_busy", 64'(busy1), 64'd0);
    check("mr_rst_valid", 64'(v1), 64'd0);
    check("mr_rst_w", w1, 64'd0);
    check("mr_rst_idx", 64'(idx1), 64'd0);
    check("mr_rst_en", 64'(en1), 64'd0);
    check("mr_rst_done", 64'(done1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(0, 100, 3, 1'b0, 1'b0, 1'b0);
    run(0, 100, 3, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
